// File: rtl/addsub_result_fifo.sv
// rtl/addsub_result_fifo.sv - result FIFO with status flags for the 4-bit adder/subtractor
// Optional per-push statistics counters are enabled by defining ADDSUB_RESULT_CNT_EN.
module addsub_result_fifo #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] sum,
  input  logic       cout,
  input  logic       mode,
  input  logic       a_msb,
  input  logic       b_msb,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_sum,
  output logic [3:0] out_flags,
  output logic       overrun
`ifdef ADDSUB_RESULT_CNT_EN
  ,
  output logic [7:0] result_cnt,
  output logic [7:0] ovf_cnt
`endif
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [3:0]     mem_sum   [DEPTH];
  logic [3:0]     mem_flags [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  logic       flag_v;
  logic [3:0] flags_in;
  logic       push;
  logic       pop;

  // Flags derived from the incoming result; subtract overflows when operand signs differ.
  always_comb begin
    if (mode) begin
      flag_v = (a_msb == b_msb) && (sum[3] != a_msb);
    end else begin
      flag_v = (a_msb != b_msb) && (sum[3] != a_msb);
    end
    flags_in = {flag_v, sum[3], (sum == 4'd0), cout};
  end

  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Head entry straight from storage; forced to zero while empty.
  assign out_sum   = out_valid ? mem_sum[rd_ptr]   : 4'd0;
  assign out_flags = out_valid ? mem_flags[rd_ptr] : 4'd0;

  // Storage write; contents are not cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_sum[wr_ptr]   <= sum;
      mem_flags[wr_ptr] <= flags_in;
    end
  end

  // Pointers, occupancy and sticky overrun; reset discards everything in the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
      if (in_valid && !in_ready) begin
        overrun <= 1'b1;
      end
    end
  end

`ifdef ADDSUB_RESULT_CNT_EN
  // Accepted-push counter wraps; overflow-result counter saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_cnt <= 8'd0;
      ovf_cnt    <= 8'd0;
    end else if (push) begin
      result_cnt <= result_cnt + 8'd1;
      if (flag_v && (ovf_cnt != 8'hFF)) begin
        ovf_cnt <= ovf_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_addsub_result_fifo.sv
// tb/tb_addsub_result_fifo.sv - self-checking bench for addsub_result_fifo (ADDSUB_RESULT_CNT_EN aware)
module tb_addsub_result_fifo;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] sum = 4'd0;
  logic       cout = 1'b0;
  logic       mode = 1'b0;
  logic       a_msb = 1'b0;
  logic       b_msb = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_sum;
  logic [3:0] out_flags;
  logic       overrun;
`ifdef ADDSUB_RESULT_CNT_EN
  logic [7:0] result_cnt;
  logic [7:0] ovf_cnt;
`endif

  addsub_result_fifo #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum       (sum),
    .cout      (cout),
    .mode      (mode),
    .a_msb     (a_msb),
    .b_msb     (b_msb),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_flags (out_flags),
    .overrun   (overrun)
`ifdef ADDSUB_RESULT_CNT_EN
    ,
    .result_cnt(result_cnt),
    .ovf_cnt   (ovf_cnt)
`endif
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // Reference model: a queue of {sum, flags} entries plus sticky/statistics state.
  logic [7:0] mq[$];
  logic       m_overrun = 1'b0;
  int         m_rcnt = 0;
  int         m_ocnt = 0;

  function automatic logic [3:0] ref_flags(logic [3:0] s, logic c, logic md, logic a, logic b);
    logic eff_b;
    logic v;
    eff_b = md ? b : ~b;   // subtraction adds the negated b, flipping its sign
    v = (a == eff_b) && (s[3] != a);
    return {v, s[3], (s == 4'd0), c};
  endfunction

  task automatic model_update();
    logic push_ok;
    logic pop_ok;
    logic [3:0] f;
    if (rst) begin
      mq.delete();
      m_overrun = 1'b0;
      m_rcnt = 0;
      m_ocnt = 0;
    end else begin
      push_ok = in_valid && (mq.size() < DEPTH);
      pop_ok  = out_ready && (mq.size() > 0);
      f = ref_flags(sum, cout, mode, a_msb, b_msb);
      if (in_valid && !push_ok) m_overrun = 1'b1;
      if (pop_ok) void'(mq.pop_front());
      if (push_ok) begin
        mq.push_back({sum, f});
        m_rcnt = (m_rcnt + 1) % 256;
        if (f[3] && m_ocnt < 255) m_ocnt = m_ocnt + 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [7:0] head;
    head = (mq.size() > 0) ? mq[0] : 8'h00;
    chk("out_valid", {7'd0, out_valid}, {7'd0, (mq.size() > 0)});
    chk("in_ready",  {7'd0, in_ready},  {7'd0, (mq.size() < DEPTH)});
    chk("out_sum",   {4'd0, out_sum},   {4'd0, head[7:4]});
    chk("out_flags", {4'd0, out_flags}, {4'd0, head[3:0]});
    chk("overrun",   {7'd0, overrun},   {7'd0, m_overrun});
`ifdef ADDSUB_RESULT_CNT_EN
    chk("result_cnt", result_cnt, 8'(m_rcnt));
    chk("ovf_cnt",    ovf_cnt,    8'(m_ocnt));
`endif
  endtask

  task automatic cyc();
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic drive(input logic v, input logic [3:0] s, input logic c,
                       input logic md, input logic a, input logic b, input logic r);
    in_valid = v; sum = s; cout = c; mode = md; a_msb = a; b_msb = b; out_ready = r;
  endtask

  task automatic drive_rand(input logic v, input logic r);
    drive(v, 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), r);
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst_out_valid", {7'd0, out_valid}, 8'd0);
    chk("rst_in_ready",  {7'd0, in_ready},  8'd1);
    chk("rst_overrun",   {7'd0, overrun},   8'd0);
    chk("rst_out_sum",   {4'd0, out_sum},   8'd0);

    // First push: visible only after the edge
    drive(1, 4'h5, 0, 1, 0, 0, 0);
    #1;
    chk("no_same_cycle_valid", {7'd0, out_valid}, 8'd0);
    cyc();
    chk("first_sum",   {4'd0, out_sum},   8'h05);
    chk("first_flags", {4'd0, out_flags}, 8'h00);

    // Add overflow 7+1 replaces the head (push+pop)
    drive(1, 4'h8, 0, 1, 0, 0, 1);
    cyc();
    chk("addv_sum",   {4'd0, out_sum},   8'h08);
    chk("addv_flags", {4'd0, out_flags}, 8'h0C);

    // Subtract giving zero with carry
    drive(1, 4'h0, 1, 0, 0, 0, 1);
    cyc();
    chk("subz_flags", {4'd0, out_flags}, 8'h03);
    drive(0, 4'h0, 0, 0, 0, 0, 1);
    cyc();
    chk("drained", {7'd0, out_valid}, 8'd0);

    // Fill with consumer stalled, then overrun attempt
    for (int i = 0; i < DEPTH; i++) begin
      drive_rand(1, 0);
      cyc();
    end
    chk("full_in_ready", {7'd0, in_ready}, 8'd0);
    drive(1, 4'hF, 1, 1, 1, 1, 0);
    cyc();
    chk("overrun_set", {7'd0, overrun}, 8'd1);
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 4'h0, 0, 0, 0, 0, 1);
      cyc();
    end
    chk("empty_after_pops", {7'd0, out_valid}, 8'd0);

    // Two stored entries, six simultaneous push/pop cycles across pointer wrap
    for (int i = 0; i < 2; i++) begin
      drive_rand(1, 0);
      cyc();
    end
    for (int i = 0; i < 6; i++) begin
      drive_rand(1, 1);
      cyc();
      chk("steady_count", 8'(mq.size()), 8'd2);
    end
    drive(0, 4'h0, 0, 0, 0, 0, 1);
    cyc();
    cyc();

    // Reset with three stored and a push pending
    for (int i = 0; i < 3; i++) begin
      drive_rand(1, 0);
      cyc();
    end
    drive(1, 4'hA, 0, 1, 0, 1, 0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("midrst_out_valid", {7'd0, out_valid}, 8'd0);
    chk("midrst_in_ready",  {7'd0, in_ready},  8'd1);
    chk("midrst_overrun",   {7'd0, overrun},   8'd0);
    drive(0, 4'h0, 0, 0, 0, 0, 1);
    cyc();
    chk("midrst_no_ghost", {7'd0, out_valid}, 8'd0);

    // 300 accepted pushes, exactly two with V=1
    for (int i = 0; i < 300; i++) begin
      if (i == 17 || i == 211) begin
        drive(1, {1'b1, 3'($urandom)}, 1'($urandom), 1, 0, 0, 1);
      end else begin
        drive(1, 4'($urandom), 1'($urandom), 1, 0, 1, 1);
      end
      cyc();
    end
`ifdef ADDSUB_RESULT_CNT_EN
    chk("result_cnt_300", result_cnt, 8'd44);
    chk("ovf_cnt_300",    ovf_cnt,    8'd2);
`endif

    // Random traffic with occasional reset
    for (int i = 0; i < 500; i++) begin
      drive_rand(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0));
      rst = ($urandom_range(0, 59) == 0);
      cyc();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
